// File: rtl/pr_iter_sequencer.sv
// ---------------------------------------------------------------------------
// pr_iter_sequencer
//
// Iteration sequencer for the four-engine PageRank fabric. Each iteration is
// started on every engine with one broadcast pulse. The block then waits at a
// barrier until every engine has reported completion at least once. After
// MAX_ITER iterations it loads the node-value snapshot register and runs the
// sorter. A watchdog covers both waits, so a stalled path ends in a sticky
// error state instead of a hang.
//
// Ports
//   i_clk             single clock, rising edge
//   i_reset           synchronous, active-high; clears all state
//   i_go              start request, honoured only in IDLE or DONE
//   i_pe_iter_done    per-engine iteration complete (pulse or level)
//   i_sort_done       sorter completion
//   o_pe_start        one-cycle broadcast iteration start
//   o_pe_hold         engines frozen while high
//   o_snapshot        one-cycle load enable for the snapshot register
//   o_sort_start      one-cycle sorter start
//   o_iter_count      completed iterations in the current run
//   o_busy            high in every state except IDLE, DONE, ERR
//   o_done            run complete, held until the next go
//   o_timeout         sticky watchdog error
//
// State table
//   state      | meaning
//   S_IDLE     | after reset, engines held, waiting for go
//   S_ISSUE    | pe_start pulse, barrier mask and watchdog cleared
//   S_WAIT     | barrier: collect done bits until all engines reported
//   S_SYNC     | count the finished iteration, pick next iteration or snapshot
//   S_SNAP     | snapshot pulse, engines frozen from here on
//   S_SORT_GO  | sort_start pulse, watchdog cleared
//   S_SORT_WAIT| wait for sort_done
//   S_DONE     | run complete, waiting for go
//   S_ERR      | watchdog expired; only reset leaves
// ---------------------------------------------------------------------------
module pr_iter_sequencer #(
    parameter int NUM_PE   = 4,
    parameter int MAX_ITER = 16,
    parameter int ITER_W   = 8,
    parameter int TIMEOUT  = 1024,
    parameter int TMO_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_go,
    input  logic [NUM_PE-1:0] i_pe_iter_done,
    input  logic              i_sort_done,
    output logic              o_pe_start,
    output logic              o_pe_hold,
    output logic              o_snapshot,
    output logic              o_sort_start,
    output logic [ITER_W-1:0] o_iter_count,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SYNC,
        S_SNAP,
        S_SORT_GO,
        S_SORT_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ITER_W-1:0] LP_MAX_ITER = ITER_W'(MAX_ITER);
    localparam logic [TMO_W-1:0]  LP_WDOG_TC  = TMO_W'(TIMEOUT - 1);

    state_t              r_state;
    logic [NUM_PE-1:0]   r_mask;
    logic [TMO_W-1:0]    r_wdog;
    logic [ITER_W-1:0]   r_iter_count;
    logic                r_pe_start;
    logic                r_pe_hold;
    logic                r_snapshot;
    logic                r_sort_start;
    logic                r_busy;
    logic                r_done;
    logic                r_timeout;

    logic [NUM_PE-1:0]   w_mask_next;
    logic                w_all_done;
    logic                w_wdog_tc;
    logic [ITER_W-1:0]   w_iter_inc;
    logic                w_last_iter;
    logic [TMO_W-1:0]    w_wdog_inc;

    // A done bit arriving together with the last missing one still counts,
    // so the barrier test looks at the mask including this cycle's inputs.
    assign w_mask_next = r_mask | i_pe_iter_done;
    assign w_all_done  = &w_mask_next;
    assign w_wdog_tc   = (r_wdog == LP_WDOG_TC);
    assign w_wdog_inc  = r_wdog + TMO_W'(1);
    assign w_iter_inc  = r_iter_count + ITER_W'(1);
    assign w_last_iter = (w_iter_inc == LP_MAX_ITER);

    // Outputs are registered alongside the state, so each is set on the edge
    // that enters the state it belongs to.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_wdog       <= '0;
            r_iter_count <= '0;
            r_pe_start   <= 1'b0;
            r_pe_hold    <= 1'b1;
            r_snapshot   <= 1'b0;
            r_sort_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_pe_start   <= 1'b0;
            r_snapshot   <= 1'b0;
            r_sort_start <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_go) begin
                        r_state      <= S_ISSUE;
                        r_iter_count <= '0;
                        r_done       <= 1'b0;
                        r_pe_hold    <= 1'b0;
                        r_pe_start   <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    r_mask  <= '0;
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    r_mask <= w_mask_next;
                    r_wdog <= w_wdog_inc;
                    // Barrier completion wins over a watchdog expiring the same cycle.
                    if (w_all_done) begin
                        r_state <= S_SYNC;
                    end else if (w_wdog_tc) begin
                        r_state   <= S_ERR;
                        r_timeout <= 1'b1;
                        r_pe_hold <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end

                S_SYNC: begin
                    r_iter_count <= w_iter_inc;
                    if (w_last_iter) begin
                        r_state    <= S_SNAP;
                        r_snapshot <= 1'b1;
                        r_pe_hold  <= 1'b1;
                    end else begin
                        r_state    <= S_ISSUE;
                        r_pe_start <= 1'b1;
                    end
                end

                S_SNAP: begin
                    r_state      <= S_SORT_GO;
                    r_sort_start <= 1'b1;
                end

                S_SORT_GO: begin
                    r_wdog  <= '0;
                    r_state <= S_SORT_WAIT;
                end

                S_SORT_WAIT: begin
                    r_wdog <= w_wdog_inc;
                    if (i_sort_done) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_wdog_tc) begin
                        r_state   <= S_ERR;
                        r_timeout <= 1'b1;
                        r_pe_hold <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end

                S_ERR: begin
                    r_state <= S_ERR;
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_pe_hold <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign o_pe_start   = r_pe_start;
    assign o_pe_hold    = r_pe_hold;
    assign o_snapshot   = r_snapshot;
    assign o_sort_start = r_sort_start;
    assign o_iter_count = r_iter_count;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_pr_iter_sequencer.sv
module tb_pr_iter_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, reset_b, go, sort_done, sel_b;
    logic [3:0] pe_done;

    logic       a_pe_start, a_pe_hold, a_snapshot, a_sort_start, a_busy, a_done, a_timeout;
    logic [7:0] a_iter;
    logic       b_pe_start, b_pe_hold, b_snapshot, b_sort_start, b_busy, b_done, b_timeout;
    logic [7:0] b_iter;

    // Instance A: MAX_ITER=3, instance B: MAX_ITER=2; both TIMEOUT=20.
    pr_iter_sequencer #(.NUM_PE(4), .MAX_ITER(3), .ITER_W(8), .TIMEOUT(20), .TMO_W(16)) dut_a (
        .i_clk(clk), .i_reset(reset_a), .i_go(go), .i_pe_iter_done(pe_done),
        .i_sort_done(sort_done), .o_pe_start(a_pe_start), .o_pe_hold(a_pe_hold),
        .o_snapshot(a_snapshot), .o_sort_start(a_sort_start), .o_iter_count(a_iter),
        .o_busy(a_busy), .o_done(a_done), .o_timeout(a_timeout));

    pr_iter_sequencer #(.NUM_PE(4), .MAX_ITER(2), .ITER_W(8), .TIMEOUT(20), .TMO_W(16)) dut_b (
        .i_clk(clk), .i_reset(reset_b), .i_go(go), .i_pe_iter_done(pe_done),
        .i_sort_done(sort_done), .o_pe_start(b_pe_start), .o_pe_hold(b_pe_hold),
        .o_snapshot(b_snapshot), .o_sort_start(b_sort_start), .o_iter_count(b_iter),
        .o_busy(b_busy), .o_done(b_done), .o_timeout(b_timeout));

    logic       m_pe_start, m_pe_hold, m_snapshot, m_sort_start, m_busy, m_done, m_timeout;
    logic [7:0] m_iter;
    assign m_pe_start   = sel_b ? b_pe_start   : a_pe_start;
    assign m_pe_hold    = sel_b ? b_pe_hold    : a_pe_hold;
    assign m_snapshot   = sel_b ? b_snapshot   : a_snapshot;
    assign m_sort_start = sel_b ? b_sort_start : a_sort_start;
    assign m_busy       = sel_b ? b_busy       : a_busy;
    assign m_done       = sel_b ? b_done       : a_done;
    assign m_timeout    = sel_b ? b_timeout    : a_timeout;
    assign m_iter       = sel_b ? b_iter       : a_iter;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {pe_start, pe_hold, snapshot, sort_start, busy, done, timeout}
    function automatic int outs();
        return int'({m_pe_start, m_pe_hold, m_snapshot, m_sort_start, m_busy, m_done, m_timeout});
    endfunction

    localparam logic [6:0] O_IDLE  = 7'b0100000;
    localparam logic [6:0] O_ISSUE = 7'b1000100;
    localparam logic [6:0] O_RUN   = 7'b0000100;
    localparam logic [6:0] O_SNAP  = 7'b0110100;
    localparam logic [6:0] O_SGO   = 7'b0101100;
    localparam logic [6:0] O_SWAIT = 7'b0100100;
    localparam logic [6:0] O_DONE  = 7'b0100010;

    typedef struct {
        logic       go;
        logic [3:0] pe;
        logic       sd;
        logic [6:0] exp_o;
        int         exp_iter;
    } vec_t;

    vec_t vec[20];

    // Results of the most recent run_seq call
    int st_cyc[8];
    int st_iter[8];
    int n_st, n_snap, snap_cyc, n_ss, ss_cyc, done_cyc, tmo_cyc, end_cyc;

    // Drives go in the current cycle (cycle 0) and then models the engines:
    // engine i pulses done in cycle (WAIT entry + off_i) after each pe_start;
    // off < 0 means never. The sorter answers sd_lat cycles after sort_start.
    // With stop_ss >= 0 the run is abandoned stop_ss cycles after sort_start.
    task automatic run_seq(input int o0, input int o1, input int o2, input int o3,
                           input int rep0, input int sd_lat, input int stop_ss,
                           input int budget);
        int s;
        int w;
        bit finished;
        logic [3:0] d;
        n_st = 0; n_snap = 0; n_ss = 0;
        snap_cyc = -1; ss_cyc = -1; done_cyc = -1; tmo_cyc = -1;
        s = -1; finished = 0;
        go = 1'b1; pe_done = '0; sort_done = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            tick();
            go = 1'b0;
            if (m_pe_start) begin
                if (n_st < 8) begin
                    st_cyc[n_st]  = cyc;
                    st_iter[n_st] = int'(m_iter);
                end
                n_st++;
                s = cyc;
            end
            if (m_snapshot) begin n_snap++; snap_cyc = cyc; end
            if (m_sort_start) begin n_ss++; ss_cyc = cyc; end
            if (m_done && done_cyc < 0) done_cyc = cyc;
            if (m_timeout && tmo_cyc < 0) tmo_cyc = cyc;
            end_cyc = cyc;
            if (done_cyc >= 0 || tmo_cyc >= 0) begin finished = 1; break; end
            if (stop_ss >= 0 && ss_cyc >= 0 && cyc == ss_cyc + stop_ss) begin finished = 1; break; end
            w = s + 1;
            d = '0;
            if (s >= 0) begin
                d[0] = (o0 >= 0 && cyc == w + o0) || (rep0 >= 0 && cyc == w + rep0);
                d[1] = (o1 >= 0 && cyc == w + o1);
                d[2] = (o2 >= 0 && cyc == w + o2);
                d[3] = (o3 >= 0 && cyc == w + o3);
            end
            pe_done   = d;
            sort_done = (sd_lat >= 0 && ss_cyc >= 0 && cyc == ss_cyc + sd_lat);
        end
        pe_done = '0;
        sort_done = 1'b0;
        chk("run_completed_within_budget", int'(finished), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_time_limit: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        vec[0]  = '{1'b0, 4'hF, 1'b1, O_IDLE,  0};  // stray done/sort_done in IDLE
        vec[1]  = '{1'b0, 4'h0, 1'b0, O_IDLE,  0};
        vec[2]  = '{1'b1, 4'h0, 1'b0, O_IDLE,  0};
        vec[3]  = '{1'b0, 4'h0, 1'b0, O_ISSUE, 0};
        vec[4]  = '{1'b0, 4'hF, 1'b0, O_RUN,   0};  // WAIT, all done at once
        vec[5]  = '{1'b0, 4'h0, 1'b0, O_RUN,   0};  // SYNC
        vec[6]  = '{1'b0, 4'h0, 1'b0, O_ISSUE, 1};
        vec[7]  = '{1'b1, 4'h3, 1'b0, O_RUN,   1};  // stray go in WAIT
        vec[8]  = '{1'b0, 4'hC, 1'b0, O_RUN,   1};
        vec[9]  = '{1'b0, 4'h0, 1'b0, O_RUN,   1};  // SYNC
        vec[10] = '{1'b0, 4'h0, 1'b0, O_ISSUE, 2};
        vec[11] = '{1'b0, 4'hF, 1'b0, O_RUN,   2};
        vec[12] = '{1'b0, 4'h0, 1'b0, O_RUN,   2};  // final SYNC
        vec[13] = '{1'b0, 4'h0, 1'b0, O_SNAP,  3};
        vec[14] = '{1'b0, 4'h0, 1'b0, O_SGO,   3};
        vec[15] = '{1'b0, 4'h0, 1'b0, O_SWAIT, 3};
        vec[16] = '{1'b0, 4'h0, 1'b1, O_SWAIT, 3};
        vec[17] = '{1'b0, 4'hF, 1'b0, O_DONE,  3};
        vec[18] = '{1'b1, 4'h0, 1'b1, O_DONE,  3};
        vec[19] = '{1'b0, 4'h0, 1'b0, O_ISSUE, 0};  // restart clears iter_count

        sel_b = 1'b0; go = 1'b0; pe_done = '0; sort_done = 1'b0;
        reset_a = 1'b1; reset_b = 1'b1;
        tick(); tick();
        reset_a = 1'b0;

        // Table-driven cycle-by-cycle run on instance A
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("vec%0d_outputs", i), outs(), int'(vec[i].exp_o));
            chk($sformatf("vec%0d_iter_count", i), int'(m_iter), vec[i].exp_iter);
            go = vec[i].go; pe_done = vec[i].pe; sort_done = vec[i].sd;
            tick();
        end
        go = 1'b0; pe_done = '0; sort_done = 1'b0;
        reset_a = 1'b1; tick(); reset_a = 1'b0;
        chk("reset_from_issue_outputs", outs(), int'(O_IDLE));

        // Nominal: engines done after 5 WAIT cycles, sorter after 10
        run_seq(5, 5, 5, 5, -1, 10, -1, 200);
        chk("nom_pe_start_count", n_st, 3);
        chk("nom_first_pe_start", st_cyc[0], 1);
        chk("nom_spacing_1", st_cyc[1] - st_cyc[0], 8);
        chk("nom_spacing_2", st_cyc[2] - st_cyc[1], 8);
        chk("nom_iter_at_start1", st_iter[1], 1);
        chk("nom_iter_at_start2", st_iter[2], 2);
        chk("nom_snapshot_count", n_snap, 1);
        chk("nom_snapshot_cycle", snap_cyc, st_cyc[2] + 8);
        chk("nom_sort_start_count", n_ss, 1);
        chk("nom_sort_start_cycle", ss_cyc, snap_cyc + 1);
        chk("nom_done_cycle", done_cyc, ss_cyc + 11);
        chk("nom_done_outputs", outs(), int'(O_DONE));
        chk("nom_done_iter", int'(m_iter), 3);

        // Staggered barrier with engine 0 re-pulsing
        run_seq(2, 9, 4, 9, 6, 3, -1, 200);
        chk("stag_pe_start_count", n_st, 3);
        chk("stag_spacing_1", st_cyc[1] - st_cyc[0], 12);
        chk("stag_spacing_2", st_cyc[2] - st_cyc[1], 12);
        chk("stag_iter_at_start1", st_iter[1], 1);
        chk("stag_done_reached", int'(done_cyc >= 0), 1);
        chk("stag_final_iter", int'(m_iter), 3);

        // Last done bit lands exactly when the watchdog reaches TIMEOUT-1
        run_seq(3, 3, 19, 3, -1, 5, -1, 300);
        chk("bnd_no_timeout", tmo_cyc, -1);
        chk("bnd_pe_start_count", n_st, 3);
        chk("bnd_spacing", st_cyc[1] - st_cyc[0], 22);
        chk("bnd_done_reached", int'(done_cyc >= 0), 1);

        // Watchdog: engine 2 never answers
        run_seq(5, 5, -1, 5, -1, 5, -1, 100);
        chk("wd_pe_start_count", n_st, 1);
        chk("wd_timeout_cycle", tmo_cyc, st_cyc[0] + 1 + 20);
        chk("wd_err_outputs", outs(), 7'b0100001);
        go = 1'b1; tick(); tick(); go = 1'b0; tick();
        chk("wd_go_ignored_outputs", outs(), 7'b0100001);
        chk("wd_go_ignored_iter", int'(m_iter), 0);
        reset_a = 1'b1; tick(); reset_a = 1'b0;
        chk("wd_reset_outputs", outs(), int'(O_IDLE));
        reset_a = 1'b1;

        // Instance B (MAX_ITER=2): reset during SORT_WAIT, then a fresh run
        sel_b = 1'b1;
        reset_b = 1'b0;
        chk("b_reset_state", outs(), int'(O_IDLE));
        run_seq(1, 1, 1, 1, -1, -1, 3, 200);
        chk("b_pre_reset_sort_wait", outs(), int'(O_SWAIT));
        chk("b_pre_reset_iter", int'(m_iter), 2);
        reset_b = 1'b1; tick(); reset_b = 1'b0;
        chk("b_mid_reset_outputs", outs(), int'(O_IDLE));
        chk("b_mid_reset_iter", int'(m_iter), 0);
        run_seq(1, 1, 1, 1, -1, 4, -1, 200);
        chk("b_fresh_pe_start_count", n_st, 2);
        chk("b_fresh_iter_at_start0", st_iter[0], 0);
        chk("b_fresh_iter_at_start1", st_iter[1], 1);
        chk("b_fresh_snapshot_count", n_snap, 1);
        chk("b_fresh_done_outputs", outs(), int'(O_DONE));
        chk("b_fresh_final_iter", int'(m_iter), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
